// File: rtl/control_unit_if.sv
// rtl/control_unit_if.sv - instruction fields in, datapath control strobes out
interface control_unit_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       irq;
    logic [1:0] aluControl;
    logic [1:0] aluSrcB;
    logic       aluSrcA;
    logic [1:0] PCSource;
    logic       PCWrite;
    logic       isBranch;
    logic       lorD;
    logic       MemWrite;
    logic       IRWrite;
    logic       MemtoReg;
    logic       RegDst;
    logic       RegWrite;
    logic       isInterrupted;
    logic [3:0] state;
    logic       illegal;

    modport master (
        input  op, funct, irq,
        output aluControl, aluSrcB, aluSrcA, PCSource, PCWrite, isBranch, lorD,
               MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, isInterrupted,
               state, illegal
    );

    modport slave (
        output op, funct, irq,
        input  aluControl, aluSrcB, aluSrcA, PCSource, PCWrite, isBranch, lorD,
               MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, isInterrupted,
               state, illegal
    );
endinterface

// File: rtl/control_unit.sv
// rtl/control_unit.sv - multicycle MIPS Moore controller with interrupt fetch path
module control_unit (
    input  logic                 clk,
    input  logic                 rst_n,
    control_unit_if.master       bus
);
    typedef enum logic [3:0] {
        S_RESET    = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMREAD  = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWRITE = 4'd6,
        S_EXECUTE  = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_ADDIEXEC = 4'd10,
        S_ADDIWB   = 4'd11,
        S_JUMP     = 4'd12,
        S_INTR     = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;

    state_t curState;
    state_t nextState;
    logic   pending;
    logic   illegalFlag;
    logic   illegalSet;
    logic   rtypeOk;
    logic   isNop;
    state_t fetchPoint;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            curState    <= S_RESET;
            pending     <= 1'b0;
            illegalFlag <= 1'b0;
        end else begin
            curState <= nextState;
            // A new request on the INTR exit edge must survive the clear.
            if (bus.irq)
                pending <= 1'b1;
            else if (curState == S_INTR)
                pending <= 1'b0;
            if (illegalSet)
                illegalFlag <= 1'b1;
        end
    end

    always_comb begin
        rtypeOk = (bus.funct == FN_ADD) || (bus.funct == FN_SUB) ||
                  (bus.funct == FN_AND) || (bus.funct == FN_OR);
        isNop   = (bus.op == OP_RTYPE) && (bus.funct == 6'b000000);
        fetchPoint = (pending || bus.irq) ? S_INTR : S_FETCH;
    end

    always_comb begin
        nextState  = S_FETCH;
        illegalSet = 1'b0;
        case (curState)
            S_RESET:    nextState = S_FETCH;
            S_FETCH:    nextState = S_DECODE;
            S_INTR:     nextState = S_DECODE;
            S_DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: nextState = S_MEMADR;
                    OP_ADDI:      nextState = S_ADDIEXEC;
                    OP_BEQ:       nextState = S_BRANCH;
                    OP_J:         nextState = S_JUMP;
                    OP_RTYPE: begin
                        if (rtypeOk) begin
                            nextState = S_EXECUTE;
                        end else begin
                            nextState  = fetchPoint;
                            illegalSet = !isNop;
                        end
                    end
                    default: begin
                        nextState  = fetchPoint;
                        illegalSet = 1'b1;
                    end
                endcase
            end
            S_MEMADR:   nextState = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  nextState = S_MEMWB;
            S_EXECUTE:  nextState = S_ALUWB;
            S_ADDIEXEC: nextState = S_ADDIWB;
            S_MEMWB, S_MEMWRITE, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP:
                        nextState = fetchPoint;
            default:    nextState = S_FETCH;
        endcase
    end

    always_comb begin
        bus.aluControl    = 2'b00;
        bus.aluSrcB       = 2'b00;
        bus.aluSrcA       = 1'b0;
        bus.PCSource      = 2'b00;
        bus.PCWrite       = 1'b0;
        bus.isBranch      = 1'b0;
        bus.lorD          = 1'b0;
        bus.MemWrite      = 1'b0;
        bus.IRWrite       = 1'b0;
        bus.MemtoReg      = 1'b0;
        bus.RegDst        = 1'b0;
        bus.RegWrite      = 1'b0;
        bus.isInterrupted = 1'b0;
        case (curState)
            S_FETCH, S_INTR: begin
                bus.IRWrite       = 1'b1;
                bus.PCWrite       = 1'b1;
                bus.aluSrcB       = 2'b01;
                bus.isInterrupted = (curState == S_INTR);
            end
            // Speculative branch target computed while the opcode is decoded.
            S_DECODE:   bus.aluSrcB = 2'b11;
            S_MEMADR, S_ADDIEXEC: begin
                bus.aluSrcA = 1'b1;
                bus.aluSrcB = 2'b10;
            end
            S_MEMREAD:  bus.lorD = 1'b1;
            S_MEMWRITE: begin
                bus.lorD     = 1'b1;
                bus.MemWrite = 1'b1;
            end
            S_MEMWB: begin
                bus.MemtoReg = 1'b1;
                bus.RegWrite = 1'b1;
            end
            S_ADDIWB:   bus.RegWrite = 1'b1;
            S_ALUWB: begin
                bus.RegDst   = 1'b1;
                bus.RegWrite = 1'b1;
            end
            S_EXECUTE: begin
                bus.aluSrcA = 1'b1;
                case (bus.funct)
                    FN_SUB:  bus.aluControl = 2'b01;
                    FN_AND:  bus.aluControl = 2'b10;
                    FN_OR:   bus.aluControl = 2'b11;
                    default: bus.aluControl = 2'b00;
                endcase
            end
            S_BRANCH: begin
                bus.aluSrcA    = 1'b1;
                bus.aluControl = 2'b01;
                bus.PCSource   = 2'b01;
                bus.isBranch   = 1'b1;
            end
            S_JUMP: begin
                bus.PCSource = 2'b10;
                bus.PCWrite  = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.state   = curState;
    assign bus.illegal = illegalFlag;
endmodule
